ddr2_init_engine: RTL

- Power-up initialization sequencer for the DDR2 device; sits directly upstream of Processing_logic.
- Drives the DDR2 command/address pins (cke, cs_bar, ras_bar, cas_bar, we_bar, BA, A, odt) from reset until the JEDEC init sequence completes, then asserts ready.
- Processing_logic holds its state machine until ready=1. The top-level pin mux selects this block's outputs while ready=0.
- Mode register contents match Processing_logic timing: BL=8, sequential burst, CL=4, AL=4.

---
 rtl/ddr2_init_engine.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ddr2_init_engine.sv
// ddr2_init_engine
// Power-up initialisation sequencer for the DDR2 device. From reset it holds
// CKE low for T_PWRUP clk, then issues NOPs with CKE high for T_CKE clk, then
// walks the JEDEC init command list (precharge, EMRS2/3, EMRS1, MRS with DLL
// reset, precharge, 2x refresh, MRS, OCD default/exit). After that it raises a
// sticky ready so Processing_logic can take over the pins.
//
// Ports:
//   clk                             controller clock (2x ck)
//   reset                           asynchronous, active-high
//   ck                              DDR clock phase sampled in the clk domain
//   cke, odt                        DDR clock enable / on-die termination (odt held 0)
//   cs_bar, ras_bar, cas_bar, we_bar  active-low command pins
//   BA[1:0], A[12:0]                bank / address (mode-register payload)
//   ready                           init complete, sticky until reset
//   init_step[3:0]                  current step index, for debug
module ddr2_init_engine #(
  parameter int unsigned T_PWRUP   = 100000,
  parameter int unsigned T_CKE     = 200,
  parameter int unsigned T_RP      = 8,
  parameter int unsigned T_MRD     = 4,
  parameter int unsigned T_RFC     = 53,
  parameter int unsigned T_DLL     = 400,
  parameter logic [12:0] MR_DLLRST = 13'h0743,
  parameter logic [12:0] MR_NORM   = 13'h0643,
  parameter logic [12:0] EMR1_BASE = 13'h0024,
  parameter logic [12:0] EMR1_OCD  = 13'h03A4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ck,
  output logic        cke,
  output logic        odt,
  output logic        cs_bar,
  output logic        ras_bar,
  output logic        cas_bar,
  output logic        we_bar,
  output logic [1:0]  BA,
  output logic [12:0] A,
  output logic        ready,
  output logic [3:0]  init_step
);

  typedef enum logic [2:0] {
    S_PWRUP   = 3'd0,
    S_CKEWAIT = 3'd1,
    S_ISSUE   = 3'd2,
    S_HOLD    = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // {cs_bar, ras_bar, cas_bar, we_bar} encodings
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;

  localparam logic [3:0]  LAST_STEP  = 4'd11;
  localparam logic [16:0] PWRUP_LAST = 17'(T_PWRUP - 1);
  localparam logic [16:0] CKE_LAST   = 17'(T_CKE - 1);
  localparam logic [16:0] G_RP       = 17'(T_RP);
  localparam logic [16:0] G_MRD      = 17'(T_MRD);
  localparam logic [16:0] G_RFC      = 17'(T_RFC);
  localparam logic [16:0] G_DLL      = 17'(T_DLL);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        load_addr;  // REFRESH/NOP leave BA/A at their previous value
    logic [16:0] gap;
  } step_t;

  // Init command list: command, BA, A and the NOP gap that follows it.
  function automatic step_t step_lookup(input logic [3:0] idx);
    step_t s;
    case (idx)
      4'd0:    s = '{CMD_PRE, 2'b00, 13'h0400,  1'b1, G_RP};
      4'd1:    s = '{CMD_MRS, 2'b10, 13'h0000,  1'b1, G_MRD};
      4'd2:    s = '{CMD_MRS, 2'b11, 13'h0000,  1'b1, G_MRD};
      4'd3:    s = '{CMD_MRS, 2'b01, EMR1_BASE, 1'b1, G_MRD};
      4'd4:    s = '{CMD_MRS, 2'b00, MR_DLLRST, 1'b1, G_MRD};
      4'd5:    s = '{CMD_PRE, 2'b00, 13'h0400,  1'b1, G_RP};
      4'd6:    s = '{CMD_REF, 2'b00, 13'h0000,  1'b0, G_RFC};
      4'd7:    s = '{CMD_REF, 2'b00, 13'h0000,  1'b0, G_RFC};
      4'd8:    s = '{CMD_MRS, 2'b00, MR_NORM,   1'b1, G_DLL};
      4'd9:    s = '{CMD_MRS, 2'b01, EMR1_OCD,  1'b1, G_MRD};
      4'd10:   s = '{CMD_MRS, 2'b01, EMR1_BASE, 1'b1, G_MRD};
      default: s = '{CMD_NOP, 2'b00, 13'h0000,  1'b0, 17'd0};
    endcase
    return s;
  endfunction

  state_t      state_r, state_n;
  logic [16:0] counter_r, counter_n;
  logic [3:0]  step_r, step_n;
  logic        cke_r, cke_n;
  logic [3:0]  cmd_r, cmd_n;
  logic [1:0]  ba_r, ba_n;
  logic [12:0] a_r, a_n;
  logic        ready_r, ready_n;
  step_t       cur_s;

  // Next-state and next-output logic for the init sequencer.
  always_comb begin
    state_n   = state_r;
    counter_n = counter_r;
    step_n    = step_r;
    cke_n     = cke_r;
    cmd_n     = cmd_r;
    ba_n      = ba_r;
    a_n       = a_r;
    ready_n   = ready_r;
    cur_s     = step_lookup(step_r);

    case (state_r)
      S_PWRUP: begin
        cke_n = 1'b0;
        cmd_n = CMD_NOP;
        if (counter_r == PWRUP_LAST) begin
          cke_n     = 1'b1;
          counter_n = 17'd0;
          state_n   = S_CKEWAIT;
        end else begin
          counter_n = counter_r + 17'd1;
        end
      end
      S_CKEWAIT: begin
        cmd_n = CMD_NOP;
        if (counter_r == CKE_LAST) begin
          counter_n = 17'd0;
          step_n    = 4'd0;
          state_n   = S_ISSUE;
        end else begin
          counter_n = counter_r + 17'd1;
        end
      end
      S_ISSUE: begin
        // Launch only on a clk edge where ck is high so the 2-clk command
        // lines up with one full ck period as Processing_logic sees it.
        if (ck) begin
          cmd_n   = cur_s.cmd;
          state_n = S_HOLD;
          if (cur_s.load_addr) begin
            ba_n = cur_s.ba;
            a_n  = cur_s.a;
          end else begin
            ba_n = ba_r;
            a_n  = a_r;
          end
        end else begin
          cmd_n = CMD_NOP;
        end
      end
      S_HOLD: begin
        // Command stays registered for this second clk; GAP drops it to NOP.
        counter_n = 17'd0;
        state_n   = S_GAP;
      end
      S_GAP: begin
        cmd_n = CMD_NOP;
        // A zero gap still spends exactly one clk here.
        if ((cur_s.gap == 17'd0) || (counter_r == (cur_s.gap - 17'd1))) begin
          counter_n = 17'd0;
          if (step_r == LAST_STEP) begin
            ready_n = 1'b1;
            state_n = S_DONE;
          end else begin
            step_n  = step_r + 4'd1;
            state_n = S_ISSUE;
          end
        end else begin
          counter_n = counter_r + 17'd1;
        end
      end
      S_DONE: begin
        cmd_n   = CMD_NOP;
        cke_n   = 1'b1;
        ready_n = 1'b1;
      end
      default: begin
        state_n   = S_PWRUP;
        counter_n = 17'd0;
        step_n    = 4'd0;
        cke_n     = 1'b0;
        cmd_n     = CMD_NOP;
        ready_n   = 1'b0;
      end
    endcase
  end

  // State, counter and registered pin values; reset forces NOP with CKE low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_PWRUP;
      counter_r <= 17'd0;
      step_r    <= 4'd0;
      cke_r     <= 1'b0;
      cmd_r     <= CMD_NOP;
      ba_r      <= 2'b00;
      a_r       <= 13'h0000;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      counter_r <= counter_n;
      step_r    <= step_n;
      cke_r     <= cke_n;
      cmd_r     <= cmd_n;
      ba_r      <= ba_n;
      a_r       <= a_n;
      ready_r   <= ready_n;
    end
  end

  assign cke                               = cke_r;
  assign odt                               = 1'b0;
  assign {cs_bar, ras_bar, cas_bar, we_bar} = cmd_r;
  assign BA                                = ba_r;
  assign A                                 = a_r;
  assign ready                             = ready_r;
  assign init_step                         = step_r;

endmodule
